interlaced_buffer_ctrl: RTL and testbench

Sequencing controller for the three line-interleaved pixel BRAMs (banks A/B/C, row r stored in bank r mod 3). It converts the camera pixel stream into bank write strobes and addresses, and triple-buffers whole 320x240 frames across three slots. It arbitrates the shared read ports between the display path (requester 0) and the pose-analysis path (requester 1), and returns muxed bank data with a requester tag.

---
 rtl/interlaced_buffer_ctrl_pkg.sv | 50 +++++
 rtl/interlaced_buffer_ctrl_if.sv | 48 ++++
 rtl/interlaced_buffer_ctrl_arbiter.sv | 39 +++
 rtl/interlaced_buffer_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_interlaced_buffer_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/interlaced_buffer_ctrl_pkg.sv
// Shared types, geometry constants and address helpers for the
// line-interleaved triple-buffered pixel store.
package interlaced_pkg;

  localparam int unsigned X            = 320;
  localparam int unsigned Y            = 240;
  localparam int unsigned THIRD_OF_Y   = 80;
  localparam int unsigned SLOT_WORDS   = 25600;
  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned STARVE_LIMIT = 7;

  typedef logic [23:0] pixel_t;
  typedef logic [1:0]  slot_t;
  typedef logic [16:0] baddr_t;
  typedef logic [8:0]  col_t;
  typedef logic [7:0]  row_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} wr_state_e;

  typedef struct packed {
    logic       vld;
    logic       tag;
    logic       oor;
    logic [1:0] bsel;
  } rd_meta_t;

  function automatic baddr_t slot_base(input slot_t s, input baddr_t words = baddr_t'(SLOT_WORDS));
    case (s)
      2'd1:    slot_base = words;
      2'd2:    slot_base = words << 1;
      default: slot_base = '0;
    endcase
  endfunction

  // Exact floor(y/3) for any 8-bit y via multiply-by-reciprocal.
  function automatic logic [6:0] div3(input row_t y);
    logic [16:0] p;
    p    = 17'(y) * 17'd171;
    div3 = p[15:9];
  endfunction

  function automatic logic [1:0] mod3(input row_t y);
    row_t q;
    row_t r;
    q    = {1'b0, div3(y)};
    r    = y - (q + q + q);
    mod3 = r[1:0];
  endfunction

endpackage

// File: rtl/interlaced_buffer_ctrl_if.sv
// Camera, bank and read-requester signals of the interlaced buffer controller.
interface interlaced_buffer_ctrl_if;
  import interlaced_pkg::*;

  logic        cam_valid;
  logic        cam_frame_start;
  pixel_t      cam_pixel;
  logic [2:0]  wr_en;
  baddr_t      wr_addr;
  pixel_t      wr_data;
  logic        rd_sync;
  logic        rd0_req;
  logic        rd1_req;
  col_t        rd0_x;
  col_t        rd1_x;
  row_t        rd0_y;
  row_t        rd1_y;
  logic        rd0_gnt;
  logic        rd1_gnt;
  baddr_t      rd_addr;
  pixel_t      bank_dout_a;
  pixel_t      bank_dout_b;
  pixel_t      bank_dout_c;
  pixel_t      rd_data;
  logic        rd_valid;
  logic        rd_tag;
  logic        frame_ready;
  slot_t       rd_slot;
  slot_t       wr_slot;
  logic [7:0]  partial_frames;

  modport master (
    output cam_valid, cam_frame_start, cam_pixel, rd_sync,
           rd0_req, rd1_req, rd0_x, rd1_x, rd0_y, rd1_y,
           bank_dout_a, bank_dout_b, bank_dout_c,
    input  wr_en, wr_addr, wr_data, rd0_gnt, rd1_gnt, rd_addr,
           rd_data, rd_valid, rd_tag, frame_ready, rd_slot, wr_slot, partial_frames
  );

  modport slave (
    input  cam_valid, cam_frame_start, cam_pixel, rd_sync,
           rd0_req, rd1_req, rd0_x, rd1_x, rd0_y, rd1_y,
           bank_dout_a, bank_dout_b, bank_dout_c,
    output wr_en, wr_addr, wr_data, rd0_gnt, rd1_gnt, rd_addr,
           rd_data, rd_valid, rd_tag, frame_ready, rd_slot, wr_slot, partial_frames
  );

endinterface

// File: rtl/interlaced_buffer_ctrl_arbiter.sv
// Two-requester read-port arbiter: requester 0 has priority, requester 1
// wins once it has been refused LIMIT consecutive requesting cycles.
module buffer_rd_arbiter
  import interlaced_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic winner_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;

  always_comb begin
    starved  = (starve_q >= CW'(LIMIT));
    gnt1_o   = rst_n && req1_i && (!req0_i || starved);
    gnt0_o   = rst_n && req0_i && !gnt1_o;
    winner_o = gnt1_o;
    starve_d = starve_q;
    if (gnt1_o)
      starve_d = '0;
    else if (req1_i && !starved)
      starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/interlaced_buffer_ctrl.sv
// Pixel-stream to banked-BRAM write sequencer with triple-buffered frame slots
// and an arbitrated, fully pipelined shared read port.
//   state    | meaning
//   ST_IDLE  | waiting for cam_valid && cam_frame_start
//   ST_WRITE | storing one pixel per cam_valid, raster order
//   ST_DONE  | frame complete: publish slot, pick next write slot
module interlaced_buffer_ctrl
  import interlaced_pkg::*;
#(
  parameter int unsigned COLS  = X,
  parameter int unsigned ROWS  = Y,
  parameter int unsigned LAT   = RD_LAT,
  parameter int unsigned LIMIT = STARVE_LIMIT
) (
  input logic clk,
  input logic reset_n,
  interlaced_buffer_ctrl_if.slave bus
);

  localparam baddr_t WORDS    = baddr_t'(COLS * ROWS / 3);
  localparam col_t   LAST_COL = col_t'(COLS - 1);
  localparam row_t   LAST_ROW = row_t'(ROWS - 1);

  wr_state_e  state_q;
  col_t       col_q;
  row_t       row_q;
  logic [1:0] rmod_q;
  baddr_t     line_q;
  logic [2:0] wr_en_q;
  baddr_t     wr_addr_q;
  pixel_t     wr_data_q;
  logic [7:0] partial_q;
  logic       frame_ready_q;
  slot_t      wr_slot_q, wr_slot_d;
  slot_t      rd_slot_q, rd_slot_d;
  slot_t      latest_q, latest_d;
  baddr_t     base_w;

  assign base_w = slot_base(wr_slot_q, WORDS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      rmod_q        <= '0;
      line_q        <= '0;
      wr_en_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      partial_q     <= '0;
      frame_ready_q <= 1'b0;
    end else begin
      wr_en_q   <= '0;
      wr_data_q <= bus.cam_pixel;
      case (state_q)
        ST_IDLE, ST_WRITE: begin
          if (bus.cam_valid && bus.cam_frame_start) begin
            // A frame start always lands at (0,0) of the current write slot.
            wr_en_q   <= 3'b001;
            wr_addr_q <= base_w;
            col_q     <= col_t'(1);
            row_q     <= '0;
            rmod_q    <= '0;
            line_q    <= '0;
            state_q   <= ST_WRITE;
            if (state_q == ST_WRITE && partial_q != 8'hFF)
              partial_q <= partial_q + 8'd1;
          end else if (bus.cam_valid && state_q == ST_WRITE) begin
            wr_en_q   <= 3'b001 << rmod_q;
            wr_addr_q <= base_w + line_q + baddr_t'(col_q);
            if (col_q == LAST_COL) begin
              col_q <= '0;
              if (row_q == LAST_ROW) begin
                state_q <= ST_DONE;
              end else begin
                row_q <= row_q + 8'd1;
                if (rmod_q == 2'd2) begin
                  rmod_q <= '0;
                  line_q <= line_q + baddr_t'(COLS);
                end else begin
                  rmod_q <= rmod_q + 2'd1;
                end
              end
            end else begin
              col_q <= col_q + 9'd1;
            end
          end
        end
        ST_DONE: begin
          frame_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Completion is applied before a coincident rd_sync so the reader can
  // take the slot that just finished.
  always_comb begin
    latest_d  = latest_q;
    wr_slot_d = wr_slot_q;
    rd_slot_d = rd_slot_q;
    if (state_q == ST_DONE) begin
      latest_d  = wr_slot_q;
      wr_slot_d = 2'd3 - wr_slot_q - rd_slot_q;
    end
    if (bus.rd_sync && latest_d != rd_slot_q)
      rd_slot_d = latest_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_slot_q <= 2'd0;
      rd_slot_q <= 2'd2;
      latest_q  <= 2'd2;
    end else begin
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      latest_q  <= latest_d;
    end
  end

  logic     gnt0, gnt1, winner;
  col_t     sel_x;
  row_t     sel_y;
  logic     sel_oor;
  baddr_t   sel_addr;
  baddr_t   rd_addr_q;
  rd_meta_t meta_q [LAT+1];
  rd_meta_t meta_out;

  buffer_rd_arbiter #(.LIMIT(LIMIT)) u_arb (
    .clk      (clk),
    .rst_n    (reset_n),
    .req0_i   (bus.rd0_req),
    .req1_i   (bus.rd1_req),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .winner_o (winner)
  );

  always_comb begin
    sel_x    = winner ? bus.rd1_x : bus.rd0_x;
    sel_y    = winner ? bus.rd1_y : bus.rd0_y;
    sel_oor  = (sel_x >= col_t'(COLS)) || (sel_y >= row_t'(ROWS));
    sel_addr = slot_base(rd_slot_q, WORDS);
    if (!sel_oor)
      sel_addr = sel_addr + baddr_t'(div3(sel_y)) * baddr_t'(COLS) + baddr_t'(sel_x);
  end

  // Bank select and range flag ride alongside the BRAM latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      for (int i = 0; i <= int'(LAT); i++) meta_q[i] <= '0;
    end else begin
      if (gnt0 || gnt1) rd_addr_q <= sel_addr;
      meta_q[0] <= '{vld: gnt0 || gnt1, tag: winner, oor: sel_oor, bsel: mod3(sel_y)};
      for (int i = 1; i <= int'(LAT); i++) meta_q[i] <= meta_q[i-1];
    end
  end

  assign meta_out = meta_q[LAT];

  always_comb begin
    bus.rd_data = '0;
    if (meta_out.vld && !meta_out.oor) begin
      case (meta_out.bsel)
        2'd0:    bus.rd_data = bus.bank_dout_a;
        2'd1:    bus.rd_data = bus.bank_dout_b;
        default: bus.rd_data = bus.bank_dout_c;
      endcase
    end
  end

  assign bus.rd_valid       = meta_out.vld;
  assign bus.rd_tag         = meta_out.tag;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.rd0_gnt        = gnt0;
  assign bus.rd1_gnt        = gnt1;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.frame_ready    = frame_ready_q;
  assign bus.partial_frames = partial_q;
  assign bus.wr_slot        = wr_slot_q;
  assign bus.rd_slot        = rd_slot_q;

endmodule

// File: tb/tb_interlaced_buffer_ctrl.sv
// Directed bench: a short-frame instance (320x6) exercises the write side,
// a full-size instance exercises the read path and arbitration.
module tb_interlaced_buffer_ctrl;
  import interlaced_pkg::*;

  localparam int XS   = 320;
  localparam int YS   = 6;
  localparam int SW_S = XS * YS / 3;
  localparam int NPIX = XS * YS;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  int   map_bad;

  interlaced_buffer_ctrl_if bf ();
  interlaced_buffer_ctrl_if bs ();

  interlaced_buffer_ctrl u_full (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bf.slave)
  );

  interlaced_buffer_ctrl #(.COLS(XS), .ROWS(YS)) u_small (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: two-cycle read latency, data tags bank id and address.
  baddr_t fa1, fa2, sa1, sa2;
  always @(posedge clk) begin
    fa1 <= bf.rd_addr;
    fa2 <= fa1;
    sa1 <= bs.rd_addr;
    sa2 <= sa1;
  end
  assign bf.bank_dout_a = {2'd1, 5'd0, fa2};
  assign bf.bank_dout_b = {2'd2, 5'd0, fa2};
  assign bf.bank_dout_c = {2'd3, 5'd0, fa2};
  assign bs.bank_dout_a = {2'd1, 5'd0, sa2};
  assign bs.bank_dout_b = {2'd2, 5'd0, sa2};
  assign bs.bank_dout_c = {2'd3, 5'd0, sa2};

  typedef struct {
    bit     who;
    col_t   x;
    row_t   y;
    bit     chk_addr;
    baddr_t addr;
    pixel_t data;
  } rd_vec_t;

  rd_vec_t vec [6];
  bit      tagq [1:20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bf.cam_valid = 0; bf.cam_frame_start = 0; bf.cam_pixel = '0; bf.rd_sync = 0;
    bf.rd0_req = 0; bf.rd1_req = 0; bf.rd0_x = '0; bf.rd1_x = '0; bf.rd0_y = '0; bf.rd1_y = '0;
    bs.cam_valid = 0; bs.cam_frame_start = 0; bs.cam_pixel = '0; bs.rd_sync = 0;
    bs.rd0_req = 0; bs.rd1_req = 0; bs.rd0_x = '0; bs.rd1_x = '0; bs.rd0_y = '0; bs.rd1_y = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Streams linear-index pixels from..to into slot w and scores each write.
  task automatic push(input int w, input int from, input int to, input bit fs);
    int row, col;
    logic [2:0] exp_en;
    map_bad = 0;
    for (int i = from; i <= to; i++) begin
      bs.cam_valid       = 1'b1;
      bs.cam_frame_start = fs && (i == from);
      bs.cam_pixel       = pixel_t'(i);
      tick();
      row    = i / XS;
      col    = i % XS;
      exp_en = 3'b001 << (row % 3);
      if (bs.wr_en !== exp_en || bs.wr_addr !== baddr_t'(w * SW_S + (row / 3) * XS + col)
          || bs.wr_data !== pixel_t'(i))
        map_bad++;
      if (w == 0 && i == 4 * XS + 7) begin
        chk("pix_r4c7_en", bs.wr_en, 3'b010);
        chk("pix_r4c7_addr", bs.wr_addr, 327);
      end
    end
    bs.cam_valid       = 1'b0;
    bs.cam_frame_start = 1'b0;
    chk("frame_map_bad_pixels", map_bad, 0);
  endtask

  task automatic end_frame(input bit sync);
    bs.rd_sync = sync;
    tick();
    bs.rd_sync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    n_checks = 0;
    n_err    = 0;

    vec[0] = '{1'b0, 9'd5,   8'd239, 1'b1, 17'd76485, {2'd3, 5'd0, 17'd76485}};
    vec[1] = '{1'b0, 9'd0,   8'd0,   1'b1, 17'd51200, {2'd1, 5'd0, 17'd51200}};
    vec[2] = '{1'b1, 9'd319, 8'd1,   1'b1, 17'd51519, {2'd2, 5'd0, 17'd51519}};
    vec[3] = '{1'b0, 9'd320, 8'd0,   1'b0, 17'd0,     24'd0};
    vec[4] = '{1'b1, 9'd0,   8'd240, 1'b0, 17'd0,     24'd0};
    vec[5] = '{1'b0, 9'd100, 8'd5,   1'b1, 17'd51620, {2'd3, 5'd0, 17'd51620}};

    // Reset state and write mapping
    do_reset();
    chk("rst_wr_en", bs.wr_en, 0);
    chk("rst_wr_addr", bs.wr_addr, 0);
    chk("rst_rd_addr", bs.rd_addr, 0);
    chk("rst_rd_valid", bs.rd_valid, 0);
    chk("rst_rd_data", bs.rd_data, 0);
    chk("rst_wr_slot", bs.wr_slot, 0);
    chk("rst_rd_slot", bs.rd_slot, 2);
    chk("rst_frame_ready", bs.frame_ready, 0);
    chk("rst_partial", bs.partial_frames, 0);
    bs.cam_valid = 1'b1;
    tick();
    bs.cam_valid = 1'b0;
    chk("idle_no_start_ignored", bs.wr_en, 0);
    push(0, 0, NPIX - 1, 1'b1);
    end_frame(1'b0);
    chk("f1_wr_slot", bs.wr_slot, 1);
    chk("f1_frame_ready", bs.frame_ready, 1);
    chk("f1_rd_slot", bs.rd_slot, 2);

    // Slot rotation
    do_reset();
    push(0, 0, NPIX - 1, 1'b1);
    end_frame(1'b0);
    push(1, 0, NPIX - 1, 1'b1);
    end_frame(1'b0);
    chk("rot_wr_slot_pre", bs.wr_slot, 0);
    bs.rd_sync = 1'b1;
    #1 chk("rot_rd_slot_before_edge", bs.rd_slot, 2);
    tick();
    bs.rd_sync = 1'b0;
    chk("rot_rd_slot", bs.rd_slot, 1);
    chk("rot_wr_slot", bs.wr_slot, 0);

    // Completion and rd_sync in the same cycle
    do_reset();
    push(0, 0, NPIX - 1, 1'b1);
    end_frame(1'b1);
    chk("sim_rd_slot", bs.rd_slot, 0);
    chk("sim_wr_slot", bs.wr_slot, 1);

    // Partial frame restart at pixel 1000
    push(1, 0, 999, 1'b1);
    bs.cam_valid = 1'b1; bs.cam_frame_start = 1'b1; bs.cam_pixel = 24'h00ABCD;
    tick();
    bs.cam_frame_start = 1'b0;
    chk("part_count", bs.partial_frames, 1);
    chk("part_wr_en", bs.wr_en, 3'b001);
    chk("part_wr_addr", bs.wr_addr, SW_S);
    chk("part_wr_slot", bs.wr_slot, 1);
    chk("part_rd_slot", bs.rd_slot, 0);
    push(1, 1, NPIX - 1, 1'b0);
    end_frame(1'b0);
    chk("part_done_wr_slot", bs.wr_slot, 2);
    chk("part_done_count", bs.partial_frames, 1);

    // Saturation of partial_frames: 1 entry + 300 restarts
    bs.cam_valid = 1'b1; bs.cam_frame_start = 1'b1;
    repeat (301) tick();
    bs.cam_frame_start = 1'b0;
    chk("part_saturate", bs.partial_frames, 255);

    // Asynchronous reset mid-frame with reads in flight
    bs.cam_pixel = 24'h123456;
    bs.rd0_req = 1'b1; bs.rd0_x = 9'd3; bs.rd0_y = 8'd1;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", bs.wr_en, 0);
    chk("arst_wr_addr", bs.wr_addr, 0);
    chk("arst_rd_addr", bs.rd_addr, 0);
    chk("arst_rd_valid", bs.rd_valid, 0);
    chk("arst_rd_data", bs.rd_data, 0);
    chk("arst_rd0_gnt", bs.rd0_gnt, 0);
    chk("arst_partial", bs.partial_frames, 0);
    chk("arst_frame_ready", bs.frame_ready, 0);
    bs.rd0_req = 1'b0; bs.cam_valid = 1'b0;
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (bs.rd_valid !== 1'b0) seen = 1'b1;
    end
    chk("arst_no_late_rd_valid", seen, 0);
    chk("arst_wr_slot", bs.wr_slot, 0);
    chk("arst_rd_slot", bs.rd_slot, 2);

    // Read path table, slot 2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (vec[k].who) begin
        bf.rd1_req = 1'b1; bf.rd1_x = vec[k].x; bf.rd1_y = vec[k].y;
      end else begin
        bf.rd0_req = 1'b1; bf.rd0_x = vec[k].x; bf.rd0_y = vec[k].y;
      end
      #1;
      chk("rd_gnt", vec[k].who ? bf.rd1_gnt : bf.rd0_gnt, 1);
      tick();
      bf.rd0_req = 1'b0; bf.rd1_req = 1'b0;
      if (vec[k].chk_addr) chk("rd_addr", bf.rd_addr, vec[k].addr);
      chk("rd_valid_t1", bf.rd_valid, 0);
      tick();
      chk("rd_valid_t2", bf.rd_valid, 0);
      tick();
      chk("rd_valid_t3", bf.rd_valid, 1);
      chk("rd_tag", bf.rd_tag, vec[k].who);
      chk("rd_data", bf.rd_data, vec[k].data);
    end

    // Arbitration with both requesters held for 20 cycles
    do_reset();
    bf.rd0_x = 9'd1; bf.rd0_y = 8'd0; bf.rd1_x = 9'd2; bf.rd1_y = 8'd0;
    for (int c = 1; c <= 23; c++) begin
      if (c >= 4) begin
        chk("arb_rd_valid", bf.rd_valid, 1);
        chk("arb_rd_tag", bf.rd_tag, tagq[c-3]);
      end
      bf.rd0_req = (c <= 20);
      bf.rd1_req = (c <= 20);
      #1;
      if (c <= 20) begin
        tagq[c] = (c == 8 || c == 16);
        chk("arb_gnt_pair", {30'd0, bf.rd1_gnt, bf.rd0_gnt}, {30'd0, tagq[c], !tagq[c]});
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
